// File: rtl/rd3_frame_sched.sv
// Radix-3 frame scheduler: buffers one N-sample frame in three banks, then issues
// N/3 butterfly triplets back to back with an index/last tag aligned to the butterfly output.
module rd3_frame_sched #(
  parameter int DW     = 13,
  parameter int N      = 27,
  parameter int BF_LAT = 3,
  parameter int AW     = ((N / 3) > 1) ? $clog2(N / 3) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 di_vld,
  input  logic signed [DW-1:0] di_re,
  input  logic signed [DW-1:0] di_im,
  output logic                 di_rdy,
  output logic                 bf_vld,
  output logic signed [DW-1:0] bf_in1_re,
  output logic signed [DW-1:0] bf_in1_im,
  output logic signed [DW-1:0] bf_in2_re,
  output logic signed [DW-1:0] bf_in2_im,
  output logic signed [DW-1:0] bf_in3_re,
  output logic signed [DW-1:0] bf_in3_im,
  output logic [AW-1:0]        bf_idx,
  output logic                 bf_last,
  output logic                 res_vld,
  output logic [AW-1:0]        res_idx,
  output logic                 res_last,
  output logic                 ovf
);

  localparam int            N3        = N / 3;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N3 - 1);

  if ((N % 3) != 0 || N < 3) begin : g_bad_n
    $error("rd3_frame_sched: N must be a positive multiple of 3");
  end
  if (BF_LAT < 1) begin : g_bad_lat
    $error("rd3_frame_sched: BF_LAT must be at least 1");
  end

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [1:0]      wr_bank;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_cnt;
  logic            wr_en;
  logic            rd_en_p0;
  logic            wr_last;

  logic [2*DW-1:0] bank0 [N3];
  logic [2*DW-1:0] bank1 [N3];
  logic [2*DW-1:0] bank2 [N3];
  logic [2*DW-1:0] rd0_p0;
  logic [2*DW-1:0] rd1_p0;
  logic [2*DW-1:0] rd2_p0;

  logic            dly_vld  [BF_LAT];
  logic [AW-1:0]   dly_idx  [BF_LAT];
  logic            dly_last [BF_LAT];

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    di_rdy   = 1'b0;
    wr_en    = 1'b0;
    rd_en_p0 = 1'b0;
    wr_last  = 1'b0;
    case (state)
      FILL: begin
        di_rdy  = 1'b1;
        wr_en   = di_vld;
        wr_last = di_vld && (wr_bank == 2'd2) && (wr_addr == LAST_ADDR);
        if (wr_last) state_nx = ISSUE;
      end
      ISSUE: begin
        rd_en_p0 = 1'b1;
        if (rd_cnt == LAST_ADDR) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  // Write side: bank select plus in-bank address replace a k/(N/3) divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 2'd0;
      wr_addr <= '0;
      rd_cnt  <= '0;
      ovf     <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_addr == LAST_ADDR) begin
          wr_addr <= '0;
          wr_bank <= (wr_bank == 2'd2) ? 2'd0 : wr_bank + 2'd1;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
      if (rd_en_p0) rd_cnt <= (rd_cnt == LAST_ADDR) ? '0 : rd_cnt + 1'b1;
      if (di_vld && !di_rdy) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (wr_bank)
        2'd0:    bank0[wr_addr] <= {di_re, di_im};
        2'd1:    bank1[wr_addr] <= {di_re, di_im};
        2'd2:    bank2[wr_addr] <= {di_re, di_im};
        default: ;
      endcase
    end
  end

  assign rd0_p0 = bank0[rd_cnt];
  assign rd1_p0 = bank1[rd_cnt];
  assign rd2_p0 = bank2[rd_cnt];

  // Stage p0 -> p1: registered triplet read; data holds between triplets.
  always_ff @(posedge clk) begin
    if (rst) begin
      bf_vld    <= 1'b0;
      bf_last   <= 1'b0;
      bf_idx    <= '0;
      bf_in1_re <= '0;
      bf_in1_im <= '0;
      bf_in2_re <= '0;
      bf_in2_im <= '0;
      bf_in3_re <= '0;
      bf_in3_im <= '0;
    end else begin
      bf_vld  <= rd_en_p0;
      bf_last <= rd_en_p0 && (rd_cnt == LAST_ADDR);
      if (rd_en_p0) begin
        bf_idx    <= rd_cnt;
        bf_in1_re <= rd0_p0[2*DW-1:DW];
        bf_in1_im <= rd0_p0[DW-1:0];
        bf_in2_re <= rd1_p0[2*DW-1:DW];
        bf_in2_im <= rd1_p0[DW-1:0];
        bf_in3_re <= rd2_p0[2*DW-1:DW];
        bf_in3_im <= rd2_p0[DW-1:0];
      end
    end
  end

  // Stage p1 -> result: tag delay line matched to the butterfly latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BF_LAT; i++) begin
        dly_vld[i]  <= 1'b0;
        dly_idx[i]  <= '0;
        dly_last[i] <= 1'b0;
      end
    end else begin
      dly_vld[0]  <= bf_vld;
      dly_idx[0]  <= bf_idx;
      dly_last[0] <= bf_last;
      for (int i = 1; i < BF_LAT; i++) begin
        dly_vld[i]  <= dly_vld[i-1];
        dly_idx[i]  <= dly_idx[i-1];
        dly_last[i] <= dly_last[i-1];
      end
    end
  end

  assign res_vld  = dly_vld[BF_LAT-1];
  assign res_idx  = dly_idx[BF_LAT-1];
  assign res_last = dly_last[BF_LAT-1];

endmodule

// File: doc/rd3_frame_sched.md
Name: rd3_frame_sched

Overview:
- Frame scheduler in front of the radix-3 butterfly stage.
- Collects a serial stream of N complex samples into three on-chip banks. It then issues N/3 butterfly triplets (x[n], x[n+N/3], x[n+2N/3]), one per cycle, with butterfly index n.
- Carries n and a last-of-frame tag through a delay line matched to the butterfly latency, so downstream twiddle/reorder logic receives index-aligned results.

Parameters:
- DW, 13, sample component width (two's complement; matches the butterfly's sign+int+frac width)
- N, 27, frame length; must be a multiple of 3 and at least 3
- BF_LAT, 3, cycles from butterfly input valid to butterfly output valid
- AW, $clog2(N/3) (minimum 1), bank address / index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- di_vld  in  1  input sample valid
- di_re  in  DW  input sample, real part
- di_im  in  DW  input sample, imaginary part
- di_rdy  out  1  scheduler can accept a sample this cycle
- bf_vld  out  1  triplet valid; drives the butterfly di_vld
- bf_in1_re, bf_in1_im  out  DW each  x[n]
- bf_in2_re, bf_in2_im  out  DW each  x[n+N/3]
- bf_in3_re, bf_in3_im  out  DW each  x[n+2N/3]
- bf_idx  out  AW  butterfly index n of the current triplet
- bf_last  out  1  current triplet has n = N/3-1
- res_vld  out  1  bf_vld delayed BF_LAT cycles
- res_idx  out  AW  bf_idx delayed BF_LAT cycles
- res_last  out  1  bf_last delayed BF_LAT cycles
- ovf  out  1  sticky flag: di_vld asserted while di_rdy=0

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state returns to FILL; wr_cnt=0, rd_cnt=0.
  - All bf_* and res_* outputs, ovf and the delay line are cleared to 0.
  - di_rdy=1 from the first cycle after reset deasserts.
  - Reset mid-frame discards any partial frame; bank contents need not be cleared.
- Storage:
  - Three banks B0, B1, B2, each N/3 deep and 2*DW wide.
  - Sample k (0..N-1, arrival order) is written to bank k/(N/3) at address k mod (N/3).
  - Implement wr_cnt as a bank select (0..2) plus an address counter (0..N/3-1); no divider.
- State FILL:
  - di_rdy=1. Each di_vld=1 cycle writes one sample and advances wr_cnt.
  - On the write of sample N-1: wr_cnt wraps to 0 and the next state is ISSUE.
- State ISSUE:
  - di_rdy=0.
  - Each cycle reads address rd_cnt from all three banks in parallel, then increments rd_cnt.
  - When rd_cnt = N/3-1 is read: rd_cnt wraps to 0 and the next state is FILL.
  - ISSUE lasts exactly N/3 cycles with no bubbles.
- Read timing:
  - Bank read data and tags are registered.
  - A read issued in cycle t gives bf_vld=1 in cycle t+1, with bf_in1 from B0, bf_in2 from B1, bf_in3 from B2, bf_idx equal to the read address, and bf_last=1 iff address = N/3-1.
  - bf_vld=0 in all other cycles. bf_in*/bf_idx hold their last values when bf_vld=0.
- Overall latency: if sample N-1 is accepted in cycle c, bf_vld is high for cycles c+2 .. c+1+N/3.
- Frame overlap:
  - FILL of the next frame starts at cycle c+1+N/3, so di_rdy is low for N/3 cycles per frame.
  - A write in the same cycle as the final bf_vld is legal: the bank read already completed a cycle earlier.
- Result alignment:
  - Shift register of depth BF_LAT carrying {bf_vld, bf_idx, bf_last}, shifted every cycle.
  - res_* equals bf_* from BF_LAT cycles earlier.
  - No stall exists anywhere in the path; the butterfly pipeline never backpressures.
- Overflow:
  - ovf is set when di_vld=1 and di_rdy=0. That sample is dropped and wr_cnt is unchanged.
  - ovf clears only on rst.
- Arithmetic: none on data. Samples pass through bit-exact.

Test Plan:
- N=9, BF_LAT=3, continuous di_vld with sample k = (re=k, im=-k), k=0..8:
  - triplets (0,3,6), (1,4,7), (2,5,8), imaginary parts negated;
  - bf_idx = 0, 1, 2; bf_last only on idx 2;
  - first bf_vld exactly 2 cycles after sample 8 is accepted.
- Same frame, checking res_vld: res_vld is high for 3 cycles starting 3 cycles after the first bf_vld; res_idx = 0, 1, 2; res_last on the 3rd.
- Gapped input (di_vld toggling 1,0,1,0…):
  - identical triplets to the continuous case;
  - di_rdy stays 1 throughout FILL;
  - ISSUE still runs 3 consecutive cycles.
- Back-to-back frames (second frame samples 100..108 driven whenever di_rdy=1):
  - di_rdy low exactly 3 cycles between frames;
  - second frame triplets (100,103,106), (101,104,107), (102,105,108);
  - no corruption of frame 1 results.
- Hold di_vld=1 during ISSUE with value 55:
  - ovf goes to 1 and stays there;
  - 55 never appears on bf_in*;
  - next frame alignment unaffected.
- Assert rst after 5 samples of a frame, then send a full frame 0..8:
  - all outputs 0 after the reset edge;
  - the first triplet is (0,3,6), with no leftover samples from the aborted frame.
